sonic_ranger: RTL and testbench
===============================

Name: sonic_ranger

Overview:
- Drives an HC-SR04-style ultrasonic sensor and measures the echo pulse width.
- Converts the width to centimetres and publishes it as the 20-bit distance bus consumed by the game-logic stage, which jumps the dino when distance ≤ 5.
- Runs periodically on the pixel clock.
- Reports a far-away sentinel on reset and on timeout, so the consumer never sees a spurious near reading.

Parameters:
CLK_FREQ_HZ, 25_000_000, pclk frequency; US_DIV = CLK_FREQ_HZ/1_000_000 must be an integer ≥ 2
TRIG_US, 10, trigger pulse width in µs
PERIOD_US, 60_000, interval from one trigger rising edge to the next trigger rising edge
TIMEOUT_US, 30_000, maximum wait from trigger fall to echo fall before the measurement is abandoned

Ports:
pclk  in  1  clock
rst  in  1  reset
enable  in  1  level; 1 = run periodic measurements
echo  in  1  sensor echo pin, asynchronous
trig  out  1  sensor trigger pin
distance  out  20  last result in cm; 20'hFFFFF = no object / invalid
valid  out  1  one-cycle pulse when distance is updated
timeout  out  1  sticky; 1 = last measurement timed out

Behaviour:
- Reset is asynchronous and active-high on rst; clock is pclk. Reset values: trig=0, distance=20'hFFFFF, valid=0, timeout=0, state IDLE, all counters 0.
- Echo input: two-flop synchroniser, then an edge register. Rise and fall are detected 3 pclk cycles after the pin changes. Only the synchronised echo is used.
- µs tick:
  - Free-running counter 0..US_DIV-1 gives a one-cycle us_tick on wrap.
  - It is also cleared on entry to TRIG, so trigger width is exact.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, HOLD.
- IDLE:
  - trig=0; distance and timeout are held.
  - enable=1 → TRIG on the next cycle.
- TRIG:
  - trig=1 for exactly TRIG_US*US_DIV cycles.
  - The period counter (µs) starts at 0 on entry.
  - Then → WAIT_RISE with trig=0 and the timeout counter (µs) cleared.
- WAIT_RISE:
  - Synchronised echo rising edge → MEASURE, clearing cm_acc and sub58.
  - An echo already high on entry is not a rise; it must fall and rise again.
- MEASURE, on each us_tick:
  - sub58 increments.
  - When sub58 = 57 it wraps to 0 and cm_acc increments, saturating at 20'hFFFFE.
  - Result: distance = floor(echo_us/58).
- End of measurement:
  - On echo falling edge in MEASURE: next cycle distance ← cm_acc, valid=1 for one cycle, timeout ← 0, → HOLD.
- Timeout:
  - Applies in WAIT_RISE or MEASURE when timeout counter ≥ TIMEOUT_US.
  - Next cycle: distance ← 20'hFFFFF, timeout ← 1, valid=1 for one cycle, → HOLD.
  - If the timeout and the echo fall occur in the same cycle, the timeout wins.
- HOLD:
  - Wait until period counter ≥ PERIOD_US.
  - Then → TRIG if enable=1, else → IDLE.
- enable deassertion:
  - Deasserting enable mid-cycle never truncates trig or aborts a measurement.
  - It only takes effect at the HOLD exit decision.
- Counter widths: the period and timeout counters are sized to hold PERIOD_US and TIMEOUT_US and saturate; they never wrap.
- rst mid-operation returns all outputs to reset values within the same cycle, since the reset is asynchronous.

Decomposition:
- Shared package:
  - DIST_NONE = 20'hFFFFF
  - CM_PER_US_DIV = 58
  - state enum for IDLE/TRIG/WAIT_RISE/MEASURE/HOLD
  - distance width 20
- Sub-module: us_tick_gen.
  - Parameters: US_DIV.
  - Ports: pclk, rst, clr, tick.
  - Instantiated once.
- Synchroniser and FSM stay in sonic_ranger.

Test Plan (CLK_FREQ_HZ=2_000_000, so US_DIV=2; PERIOD_US=2000; TIMEOUT_US=1000):
- Reset: assert rst → distance=20'hFFFFF, trig=0, valid=0, timeout=0. Hold enable=0 for 100 cycles → trig stays 0.
- Trigger: enable=1 → trig rises 1 cycle later, stays high exactly 20 cycles. The next trig rise comes 4000 cycles after the first.
- Normal: echo high for 580 µs (1160 cycles) → exactly one valid pulse, distance=10, timeout=0.
- Boundary:
  - Echo 290 µs → distance=5.
  - Echo 347 µs → distance=5.
  - Echo 348 µs → distance=6.
  - Echo 57 µs → distance=0.
- Timeout: no echo → valid pulse with distance=20'hFFFFF and timeout=1, 1000 µs after trig falls. The following cycle with 116 µs echo → distance=2, timeout=0.
- Disturbance:
  - echo stuck high from before trig → timeout result.
  - rst asserted mid-MEASURE → immediate reset values; a new trig appears only after rst is released with enable=1.
  - enable dropped mid-MEASURE → measurement completes, then IDLE.

Source files
------------

// File: rtl/sonic_ranger_pkg.sv
// Shared types and constants for the ultrasonic ranger: result width,
// the "no object" sentinel, the µs-per-cm divisor and the FSM state set.
package sonic_ranger_pkg;

  localparam int DIST_W = 20;
  localparam logic [DIST_W-1:0] DIST_NONE = 20'hFFFFF;
  // Highest real reading; one below the sentinel so a long echo never looks like "no object".
  localparam logic [DIST_W-1:0] CM_SAT = 20'hFFFFE;
  localparam int CM_PER_US_DIV = 58;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLD
  } ranger_state_e;

endpackage

// File: rtl/sonic_ranger_tick.sv
// Free-running microsecond strobe: one-cycle tick every US_DIV clocks,
// restartable so the trigger pulse can be timed from a known phase.
module us_tick_gen #(
  parameter int US_DIV = 25
) (
  input  logic pclk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(US_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick = (cnt_q == LAST);
    if (clr || tick) cnt_d = '0;
    else             cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sonic_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo width measurement in µs,
// conversion to cm and a sentinel result when the echo never completes.
module sonic_ranger
  import sonic_ranger_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int TRIG_US     = 10,
  parameter int PERIOD_US   = 60_000,
  parameter int TIMEOUT_US  = 30_000
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              enable,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] distance,
  output logic              valid,
  output logic              timeout
);

  localparam int US_DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int PW = $clog2(PERIOD_US + 1);
  localparam int TW = $clog2(TIMEOUT_US + 1);
  localparam logic [PW-1:0] PERIOD_LIM = PW'(PERIOD_US);
  localparam logic [PW-1:0] TRIG_LIM   = PW'(TRIG_US);
  localparam logic [TW-1:0] TMO_LIM    = TW'(TIMEOUT_US);
  localparam logic [5:0]    SUB_LAST   = 6'(CM_PER_US_DIV - 1);

  ranger_state_e     state_q, state_d;
  logic [1:0]        echo_sync_q, echo_sync_d;
  logic              echo_prev_q, echo_prev_d;
  logic              trig_q, trig_d;
  logic              valid_q, valid_d;
  logic              timeout_q, timeout_d;
  logic [DIST_W-1:0] distance_q, distance_d;
  logic [DIST_W-1:0] cm_acc_q, cm_acc_d;
  logic [5:0]        sub58_q, sub58_d;
  logic [PW-1:0]     period_q, period_d, period_inc;
  logic [TW-1:0]     tmo_q, tmo_d, tmo_inc;
  logic              us_tick, tick_clr, echo_rise, echo_fall;

  us_tick_gen #(.US_DIV(US_DIV)) u_tick (
    .pclk (pclk),
    .rst  (rst),
    .clr  (tick_clr),
    .tick (us_tick)
  );

  // Next-state and datapath; exits compare against the incremented count
  // so the trigger width and period land exactly on the µs boundary.
  always_comb begin
    echo_sync_d = {echo_sync_q[0], echo};
    echo_prev_d = echo_sync_q[1];
    echo_rise   = echo_sync_q[1] & ~echo_prev_q;
    echo_fall   = ~echo_sync_q[1] & echo_prev_q;

    period_inc = (us_tick && period_q != PERIOD_LIM) ? period_q + 1'b1 : period_q;
    tmo_inc    = (us_tick && tmo_q != TMO_LIM) ? tmo_q + 1'b1 : tmo_q;

    state_d    = state_q;
    valid_d    = 1'b0;
    timeout_d  = timeout_q;
    distance_d = distance_q;
    cm_acc_d   = cm_acc_q;
    sub58_d    = sub58_q;
    period_d   = period_inc;
    tmo_d      = tmo_q;
    tick_clr   = 1'b0;

    unique case (state_q)
      IDLE: begin
        period_d = '0;
        if (enable) state_d = TRIG;
      end
      TRIG: begin
        if (period_inc >= TRIG_LIM) begin
          state_d = WAIT_RISE;
          tmo_d   = '0;
        end
      end
      WAIT_RISE: begin
        tmo_d = tmo_inc;
        if (tmo_q >= TMO_LIM) begin
          distance_d = DIST_NONE;
          timeout_d  = 1'b1;
          valid_d    = 1'b1;
          state_d    = HOLD;
        end else if (echo_rise) begin
          cm_acc_d = '0;
          sub58_d  = '0;
          state_d  = MEASURE;
        end
      end
      MEASURE: begin
        tmo_d = tmo_inc;
        if (us_tick) begin
          if (sub58_q == SUB_LAST) begin
            sub58_d = '0;
            if (cm_acc_q != CM_SAT) cm_acc_d = cm_acc_q + 1'b1;
          end else begin
            sub58_d = sub58_q + 1'b1;
          end
        end
        if (tmo_q >= TMO_LIM) begin
          distance_d = DIST_NONE;
          timeout_d  = 1'b1;
          valid_d    = 1'b1;
          state_d    = HOLD;
        end else if (echo_fall) begin
          distance_d = cm_acc_d;
          timeout_d  = 1'b0;
          valid_d    = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (period_inc >= PERIOD_LIM) state_d = enable ? TRIG : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == TRIG && state_q != TRIG) begin
      period_d = '0;
      tick_clr = 1'b1;
    end
    trig_d = (state_d == TRIG);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      echo_sync_q <= '0;
      echo_prev_q <= 1'b0;
      trig_q      <= 1'b0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      distance_q  <= DIST_NONE;
      cm_acc_q    <= '0;
      sub58_q     <= '0;
      period_q    <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      echo_sync_q <= echo_sync_d;
      echo_prev_q <= echo_prev_d;
      trig_q      <= trig_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
      distance_q  <= distance_d;
      cm_acc_q    <= cm_acc_d;
      sub58_q     <= sub58_d;
      period_q    <= period_d;
      tmo_q       <= tmo_d;
    end
  end

  assign trig     = trig_q;
  assign valid    = valid_q;
  assign timeout  = timeout_q;
  assign distance = distance_q;

endmodule

// File: tb/tb_sonic_ranger.sv
// Directed bench for sonic_ranger at 2 MHz (2 clocks per µs): trigger timing,
// cm conversion boundaries, timeout, and enable/reset disturbances.
module tb_sonic_ranger;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        echo = 1'b0;
  logic        trig;
  logic [19:0] distance;
  logic        valid;
  logic        timeout;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int rise_q[$];
  logic trig_prev = 1'b0;

  sonic_ranger #(
    .CLK_FREQ_HZ(2_000_000),
    .TRIG_US(10),
    .PERIOD_US(2000),
    .TIMEOUT_US(1000)
  ) dut (
    .pclk     (pclk),
    .rst      (rst),
    .enable   (enable),
    .echo     (echo),
    .trig     (trig),
    .distance (distance),
    .valid    (valid),
    .timeout  (timeout)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc++;

  always @(negedge pclk) begin
    if (trig === 1'b1 && trig_prev !== 1'b1) rise_q.push_back(cyc);
    trig_prev = trig;
    if (valid === 1'b1) valid_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic waitTrigLevel(input logic lvl, input string tag);
    for (int i = 0; i < 10000 && trig !== lvl; i++) @(negedge pclk);
    checkOutput(tag, {31'd0, trig}, {31'd0, lvl});
  endtask

  task automatic waitValid(input string tag);
    for (int i = 0; i < 5000 && valid !== 1'b1; i++) @(negedge pclk);
    checkOutput(tag, {31'd0, valid}, 32'd1);
  endtask

  task automatic driveEcho(input int us, input logic [19:0] exp_dist, input string tag);
    int v0;
    repeat (4) @(negedge pclk);
    v0 = valid_cnt;
    echo = 1'b1;
    repeat (2 * us) @(negedge pclk);
    echo = 1'b0;
    waitValid({tag, "_valid"});
    checkOutput({tag, "_dist"}, {12'd0, distance}, {12'd0, exp_dist});
    checkOutput({tag, "_tmo"}, {31'd0, timeout}, 32'd0);
    @(negedge pclk);
    checkOutput({tag, "_pulse"}, {31'd0, valid}, 32'd0);
    repeat (10) @(negedge pclk);
    checkOutput({tag, "_count"}, valid_cnt - v0, 32'd1);
  endtask

  task automatic applyStimulus(input int us, input logic [19:0] exp_dist, input string tag);
    waitTrigLevel(1'b1, {tag, "_trig_hi"});
    waitTrigLevel(1'b0, {tag, "_trig_lo"});
    driveEcho(us, exp_dist, tag);
  endtask

  initial begin
    int n;
    int rc;

    repeat (3) @(negedge pclk);
    checkOutput("rst_dist", {12'd0, distance}, 32'hFFFFF);
    checkOutput("rst_trig", {31'd0, trig}, 32'd0);
    checkOutput("rst_valid", {31'd0, valid}, 32'd0);
    checkOutput("rst_tmo", {31'd0, timeout}, 32'd0);
    rst = 1'b0;

    n = 0;
    repeat (100) begin
      @(negedge pclk);
      if (trig !== 1'b0) n++;
    end
    checkOutput("idle_trig_low", n, 0);

    enable = 1'b1;
    @(negedge pclk);
    checkOutput("trig_delay", {31'd0, trig}, 32'd1);
    n = 0;
    while (trig === 1'b1 && n < 100) begin
      n++;
      @(negedge pclk);
    end
    checkOutput("trig_width", n, 20);
    driveEcho(580, 20'd10, "echo580");

    applyStimulus(290, 20'd5, "echo290");
    checkOutput("trig_period", (rise_q.size() >= 2) ? rise_q[1] - rise_q[0] : -1, 4000);
    applyStimulus(347, 20'd5, "echo347");
    applyStimulus(348, 20'd6, "echo348");
    applyStimulus(57, 20'd0, "echo57");

    waitTrigLevel(1'b1, "tmo_trig_hi");
    waitTrigLevel(1'b0, "tmo_trig_lo");
    n = 0;
    while (valid !== 1'b1 && n < 5000) begin
      @(negedge pclk);
      n++;
    end
    checkOutput("tmo_latency", n, 2001);
    checkOutput("tmo_dist", {12'd0, distance}, 32'hFFFFF);
    checkOutput("tmo_flag", {31'd0, timeout}, 32'd1);

    applyStimulus(116, 20'd2, "echo116");

    echo = 1'b1;
    waitTrigLevel(1'b1, "stuck_trig_hi");
    waitTrigLevel(1'b0, "stuck_trig_lo");
    waitValid("stuck_valid");
    checkOutput("stuck_dist", {12'd0, distance}, 32'hFFFFF);
    checkOutput("stuck_tmo", {31'd0, timeout}, 32'd1);
    echo = 1'b0;

    waitTrigLevel(1'b1, "endrop_trig_hi");
    waitTrigLevel(1'b0, "endrop_trig_lo");
    repeat (4) @(negedge pclk);
    echo = 1'b1;
    repeat (100) @(negedge pclk);
    enable = 1'b0;
    repeat (2 * 348 - 100) @(negedge pclk);
    echo = 1'b0;
    waitValid("endrop_valid");
    checkOutput("endrop_dist", {12'd0, distance}, 32'd6);
    rc = rise_q.size();
    repeat (5000) @(negedge pclk);
    checkOutput("endrop_idle", rise_q.size() - rc, 0);
    enable = 1'b1;
    @(negedge pclk);
    checkOutput("reenable_trig", {31'd0, trig}, 32'd1);

    waitTrigLevel(1'b0, "rst_mid_trig_lo");
    repeat (4) @(negedge pclk);
    echo = 1'b1;
    repeat (100) @(negedge pclk);
    rst = 1'b1;
    #1;
    checkOutput("rstmid_dist", {12'd0, distance}, 32'hFFFFF);
    checkOutput("rstmid_trig", {31'd0, trig}, 32'd0);
    checkOutput("rstmid_valid", {31'd0, valid}, 32'd0);
    checkOutput("rstmid_tmo", {31'd0, timeout}, 32'd0);
    rc = rise_q.size();
    repeat (50) @(negedge pclk);
    checkOutput("rstmid_hold_no_trig", rise_q.size() - rc, 0);
    enable = 1'b0;
    echo = 1'b0;
    rst = 1'b0;
    repeat (50) @(negedge pclk);
    checkOutput("rstrel_no_trig", rise_q.size() - rc, 0);
    checkOutput("rstrel_dist", {12'd0, distance}, 32'hFFFFF);
    enable = 1'b1;
    @(negedge pclk);
    checkOutput("rstrel_trig", {31'd0, trig}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
